// File: rtl/user_cmd_dispatcher.sv
// user_cmd_dispatcher: routes user commands into per-rank registered FIFOs by rank field.
// Optional per-rank pop counters on cmd_cnt when DISPATCH_CNT_EN is defined.
module user_cmd_dispatcher #(
  parameter int unsigned NUM_RANKS = 4,
  parameter int unsigned RANK_BITS = 2,
  parameter int unsigned ROW_BITS  = 14,
  parameter int unsigned COL_BITS  = 10,
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned CW = ROW_BITS + COL_BITS + BA_BITS + 6,
  localparam int unsigned UW = CW + RANK_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [UW-1:0]           in_cmd,
  output logic                    in_ready,
  output logic [NUM_RANKS-1:0]    out_valid,
  output logic [NUM_RANKS*CW-1:0] out_cmd,
  input  logic [NUM_RANKS-1:0]    out_ready,
  output logic                    err_rank,
  output logic                    idle
`ifdef DISPATCH_CNT_EN
  ,
  output logic [NUM_RANKS*16-1:0] cmd_cnt
`endif
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam logic [CNTW-1:0]    FULL_CNT = CNTW'(DEPTH);
  localparam logic [RANK_BITS:0] NR_LIM   = (RANK_BITS + 1)'(NUM_RANKS);

  logic [CW-1:0]        mem_q    [NUM_RANKS][DEPTH];
  logic [PW-1:0]        wr_ptr_q [NUM_RANKS];
  logic [PW-1:0]        wr_ptr_d [NUM_RANKS];
  logic [PW-1:0]        rd_ptr_q [NUM_RANKS];
  logic [PW-1:0]        rd_ptr_d [NUM_RANKS];
  logic [CNTW-1:0]      cnt_q    [NUM_RANKS];
  logic [CNTW-1:0]      cnt_d    [NUM_RANKS];
  logic                 err_q, err_d;
  logic [RANK_BITS-1:0] rank;
  logic                 legal;
  logic [CNTW-1:0]      sel_cnt;
  logic [NUM_RANKS-1:0] push, pop;

  // Accept/route decode plus per-rank pointer and occupancy update
  always_comb begin
    rank    = in_cmd[UW-1 -: RANK_BITS];
    legal   = {1'b0, rank} < NR_LIM;
    sel_cnt = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (rank == RANK_BITS'(r)) sel_cnt = cnt_q[r];
    end
    in_ready = !legal || (sel_cnt < FULL_CNT);
    err_d    = in_valid && !legal;
    for (int r = 0; r < NUM_RANKS; r++) begin
      // A full rank refuses even when it pops this cycle
      push[r]     = in_valid && legal && (rank == RANK_BITS'(r)) && (cnt_q[r] < FULL_CNT);
      pop[r]      = (cnt_q[r] != '0) && out_ready[r];
      wr_ptr_d[r] = push[r] ? PW'(wr_ptr_q[r] + PW'(1)) : wr_ptr_q[r];
      rd_ptr_d[r] = pop[r]  ? PW'(rd_ptr_q[r] + PW'(1)) : rd_ptr_q[r];
      cnt_d[r]    = cnt_q[r];
      if (push[r] && !pop[r])      cnt_d[r] = cnt_q[r] + CNTW'(1);
      else if (!push[r] && pop[r]) cnt_d[r] = cnt_q[r] - CNTW'(1);
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int r = 0; r < NUM_RANKS; r++) begin
      out_valid[r]         = cnt_q[r] != '0;
      out_cmd[r*CW +: CW]  = mem_q[r][rd_ptr_q[r]];
      if (cnt_q[r] != '0) idle = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int r = 0; r < NUM_RANKS; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        cnt_q[r]    <= '0;
        for (int d = 0; d < DEPTH; d++) mem_q[r][d] <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int r = 0; r < NUM_RANKS; r++) begin
        wr_ptr_q[r] <= wr_ptr_d[r];
        rd_ptr_q[r] <= rd_ptr_d[r];
        cnt_q[r]    <= cnt_d[r];
        if (push[r]) mem_q[r][wr_ptr_q[r]] <= in_cmd[CW-1:0];
      end
    end
  end

  assign err_rank = err_q;

`ifdef DISPATCH_CNT_EN
  logic [15:0] pop_cnt_q [NUM_RANKS];
  logic [15:0] pop_cnt_d [NUM_RANKS];

  // Saturating per-rank pop counters
  always_comb begin
    for (int r = 0; r < NUM_RANKS; r++) begin
      pop_cnt_d[r]          = (pop[r] && (pop_cnt_q[r] != 16'hFFFF)) ? pop_cnt_q[r] + 16'd1
                                                                      : pop_cnt_q[r];
      cmd_cnt[r*16 +: 16]   = pop_cnt_q[r];
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (rst) pop_cnt_q[r] <= '0;
      else     pop_cnt_q[r] <= pop_cnt_d[r];
    end
  end
`endif

endmodule

// File: tb/tb_user_cmd_dispatcher.sv
// Scoreboard bench for user_cmd_dispatcher (3 ranks, so rank 3 is illegal); checks cmd_cnt when DISPATCH_CNT_EN is defined.
module tb_user_cmd_dispatcher;
  localparam int unsigned NR   = 3;
  localparam int unsigned RB   = 2;
  localparam int unsigned ROWB = 14;
  localparam int unsigned COLB = 10;
  localparam int unsigned BAB  = 3;
  localparam int unsigned DEP  = 4;
  localparam int unsigned CW   = ROWB + COLB + BAB + 6;
  localparam int unsigned UW   = CW + RB;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [UW-1:0]   in_cmd;
  logic            in_ready;
  logic [NR-1:0]   out_valid;
  logic [NR*CW-1:0] out_cmd;
  logic [NR-1:0]   out_ready;
  logic            err_rank;
  logic            idle;
`ifdef DISPATCH_CNT_EN
  logic [NR*16-1:0] cmd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: one expected-command queue per rank
  logic [CW-1:0] exp_q [NR][$];
  logic          err_exp;
  bit            synced = 1'b0;
  int            pops [NR];
  logic [RB-1:0] m_rk;
  bit            m_legal;
  bit            m_rdy;
  bit            m_idle;

  user_cmd_dispatcher #(
    .NUM_RANKS(NR), .RANK_BITS(RB), .ROW_BITS(ROWB),
    .COL_BITS(COLB), .BA_BITS(BAB), .DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cmd(in_cmd),
    .in_ready(in_ready), .out_valid(out_valid), .out_cmd(out_cmd),
    .out_ready(out_ready), .err_rank(err_rank), .idle(idle)
`ifdef DISPATCH_CNT_EN
    , .cmd_cnt(cmd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [UW-1:0] mk(input int rk, input logic [CW-1:0] body);
    return {RB'(rk), body};
  endfunction

  function automatic logic [CW-1:0] rnd_body();
    return CW'({$urandom(), $urandom()});
  endfunction

  // Monitor/scoreboard: compares pre-edge state at negedge, then advances the model for the coming edge
  always @(negedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        exp_q[r].delete();
        pops[r] = 0;
      end
      err_exp = 1'b0;
      synced  = 1'b1;
    end else if (synced) begin
      m_rk    = in_cmd[UW-1 -: RB];
      m_legal = int'(m_rk) < NR;
      m_rdy   = m_legal ? (exp_q[int'(m_rk)].size() < DEP) : 1'b1;
      m_idle  = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(m_rdy));
      chk("err_rank", 64'(err_rank), 64'(err_exp));
      for (int r = 0; r < NR; r++) begin
        if (exp_q[r].size() != 0) m_idle = 1'b0;
        chk($sformatf("out_valid[%0d]", r), 64'(out_valid[r]), 64'(exp_q[r].size() != 0));
        if (exp_q[r].size() != 0)
          chk($sformatf("out_cmd[%0d]", r), 64'(out_cmd[r*CW +: CW]), 64'(exp_q[r][0]));
`ifdef DISPATCH_CNT_EN
        chk($sformatf("cmd_cnt[%0d]", r), 64'(cmd_cnt[r*16 +: 16]), 64'(pops[r]));
`endif
      end
      chk("idle", 64'(idle), 64'(m_idle));
      for (int r = 0; r < NR; r++) begin
        if (exp_q[r].size() != 0 && out_ready[r]) begin
          void'(exp_q[r].pop_front());
          pops[r]++;
        end
      end
      if (in_valid && m_rdy && m_legal) exp_q[int'(m_rk)].push_back(in_cmd[CW-1:0]);
      err_exp = in_valid && !m_legal;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [UW-1:0] c, input logic [NR-1:0] rdy);
    in_valid  = v;
    in_cmd    = c;
    out_ready = rdy;
  endtask

  // Drive one cycle, checking in_ready against a directed expectation before the edge
  task automatic push_chk(input string name, input int rk, input logic [CW-1:0] b,
                          input logic [NR-1:0] rdy, input bit exp_rdy);
    drive(1'b1, mk(rk, b), rdy);
    #1;
    chk(name, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '1);
    repeat (DEP + 1) sync();
  endtask

  logic [CW-1:0] b23;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0);
    repeat (2) sync();
    rst = 1'b0;
    #1;
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err_rank), 64'd0);
    for (int r = 0; r < NR; r++) chk($sformatf("rst_cmd[%0d]", r), 64'(out_cmd[r*CW +: CW]), 64'd0);
    sync();

    // Read to rank 2: row 0x123, BL8, col 0x45, bank 5
    b23 = {1'b1, 1'b0, 14'h123, 1'b0, 1'b1, 1'b0, 1'b0, 10'h045, 3'd5};
    push_chk("t23_ready", 2, b23, '0, 1'b1);
    drive(1'b0, '0, '0);
    #1;
    chk("t23_valid", 64'(out_valid), 64'(3'b100));
    chk("t23_cmd", 64'(out_cmd[2*CW +: CW]), 64'(b23));
    chk("t23_idle", 64'(idle), 64'd0);
    drain();

    // Fill rank 1 with consumer stalled
    for (int i = 0; i < 5; i++) push_chk($sformatf("t24_ready%0d", i), 1, rnd_body(), '0, i < 4);
    drive(1'b0, '0, '0);
    #1;
    chk("t24_valid1", 64'(out_valid[1]), 64'd1);
    drain();

    // Full rank 0 pops while refusing a push, then accepts next cycle
    for (int i = 0; i < 4; i++) push_chk("t25_fill", 0, rnd_body(), '0, 1'b1);
    push_chk("t25_refuse", 0, rnd_body(), 3'b001, 1'b0);
    push_chk("t25_accept", 0, rnd_body(), '0, 1'b1);
    drain();

    // Illegal rank 3 is swallowed with a single-cycle error pulse
    push_chk("t26_ready", 3, rnd_body(), '0, 1'b1);
    drive(1'b0, '0, '0);
    #1;
    chk("t26_err", 64'(err_rank), 64'd1);
    chk("t26_valid", 64'(out_valid), 64'd0);
    sync();
    chk("t26_err_clr", 64'(err_rank), 64'd0);

    // Six commands through rank 2 with consumer always ready
    for (int i = 0; i < 6; i++) push_chk("t27_ready", 2, CW'(64'hA0 + 64'(i)), 3'b100, 1'b1);
    drive(1'b0, '0, 3'b100);
    repeat (2) sync();
    chk("t27_idle", 64'(idle), 64'd1);

    // Reset mid-operation with a handshake in the reset cycle
    for (int i = 0; i < 6; i++) push_chk("mid_fill", i % 3, rnd_body(), '0, 1'b1);
    rst = 1'b1;
    drive(1'b1, mk(1, rnd_body()), '1);
    sync();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("mid_idle", 64'(idle), 64'd1);
    chk("mid_valid", 64'(out_valid), 64'd0);
    sync();

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, mk(int'($urandom_range(0, 3)), rnd_body()),
            NR'($urandom));
      sync();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
